fifo_ld_req_arbiter: RTL and testbench

Shares the single load-request/response port of the FIFO controller's load unit among `N_REQ` independent MSHR hubs. Each cycle it selects at most one pending load with a round-robin policy and holds it in a one-entry output register until the memory side accepts it. It tags the load with a per-requester MSHR id and routes each returning response back to its owner. It also enforces a per-requester cap on in-flight loads and flags responses that match no outstanding load.

---
 rtl/fifo_ld_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fifo_ld_req_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ld_req_arbiter.sv
// Round-robin arbiter sharing the load unit's single memory request port among
// N_REQ MSHR hubs, with per-requester in-flight caps and response routing.
module fifo_ld_req_arbiter #(
  parameter int                  N_REQ           = 4,
  parameter int                  ADDR_W          = 40,
  parameter int                  SIZE_W          = 3,
  parameter int                  DATA_W          = 64,
  parameter int                  MSHRID_W        = 8,
  parameter logic [MSHRID_W-1:0] MSHRID_BASE     = 8'd144,
  parameter int                  MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*SIZE_W-1:0]   req_size_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic [ADDR_W-1:0]         mem_req_addr_o,
  output logic [SIZE_W-1:0]         mem_req_size_o,
  output logic [MSHRID_W-1:0]       mem_req_mshrid_o,
  input  logic                      mem_resp_valid_i,
  input  logic [MSHRID_W-1:0]       mem_resp_mshrid_i,
  input  logic [DATA_W-1:0]         mem_resp_data_i,
  output logic [N_REQ-1:0]          resp_valid_o,
  output logic [DATA_W-1:0]         resp_data_o,
  output logic                      stray_resp_o
);

  localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    winner;
  logic                grant_found;
  logic                slot_free;
  logic                accept;
  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    cnt_inc;
  logic [N_REQ-1:0]    resp_hit;
  logic                resp_match;
  logic                resp_in_range;
  logic [MSHRID_W-1:0] resp_off;
  logic [ADDR_W-1:0]   sel_addr;
  logic [SIZE_W-1:0]   sel_size;
  logic [CNT_W-1:0]    cnt [N_REQ];

  // (base + off) mod N_REQ for off < N_REQ, done with one conditional subtract.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + (IDX_W+1)'(off);
    if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
    return sum[IDX_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid_i[i] && (cnt[i] < CNT_MAX);
    end
  end

  assign slot_free = !mem_req_valid_o || mem_req_ready_i;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    grant_found = 1'b0;
    winner      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_found && eligible[wrap_add(rr_ptr, k)]) begin
        grant_found = 1'b1;
        winner      = wrap_add(rr_ptr, k);
      end
    end
  end

  // Grant is suppressed while reset is low so no request is consumed during reset.
  assign accept      = rst_n && slot_free && grant_found;
  assign req_ready_o = accept ? (N_REQ'(1) << winner) : '0;

  always_comb begin
    sel_addr = '0;
    sel_size = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_size = req_size_i[i*SIZE_W +: SIZE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= wrap_add(winner, 1);
    end
  end

  // ---------------------------------------------------------------------------
  // One-entry output slot: refills in the same cycle it drains.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      mem_req_valid_o  <= 1'b0;
      mem_req_addr_o   <= '0;
      mem_req_size_o   <= '0;
      mem_req_mshrid_o <= MSHRID_BASE;
    end else if (accept) begin
      mem_req_valid_o  <= 1'b1;
      mem_req_addr_o   <= sel_addr;
      mem_req_size_o   <= sel_size;
      mem_req_mshrid_o <= MSHRID_BASE + MSHRID_W'(winner);
    end else if (mem_req_ready_i) begin
      mem_req_valid_o  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response decode. Subtracting the base wraps ids below it to large values,
  // so a single unsigned compare checks both bounds (base + N_REQ must fit).
  // ---------------------------------------------------------------------------
  assign resp_off      = mem_resp_mshrid_i - MSHRID_BASE;
  assign resp_in_range = resp_off < MSHRID_W'(N_REQ);

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      resp_hit[i] = mem_resp_valid_i && resp_in_range &&
                    (resp_off == MSHRID_W'(i)) && (cnt[i] != '0);
      cnt_inc[i]  = accept && (winner == IDX_W'(i));
    end
  end

  assign resp_match = |resp_hit;

  // Counters cover the held request plus loads awaiting a response; a
  // same-cycle accept and matching response cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cnt_inc[i] && !resp_hit[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (!cnt_inc[i] && resp_hit[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_o <= '0;
      resp_data_o  <= '0;
      stray_resp_o <= 1'b0;
    end else begin
      resp_valid_o <= resp_hit;
      stray_resp_o <= mem_resp_valid_i && !resp_match;
      if (resp_match) resp_data_o <= mem_resp_data_i;
    end
  end

endmodule

// File: tb/tb_fifo_ld_req_arbiter.sv
// Self-checking bench for fifo_ld_req_arbiter: vector table plus hand-written
// corner sequences, with a queue scoreboard on the memory request side.
module tb_fifo_ld_req_arbiter;

  localparam int N_REQ = 4;
  localparam int ADDR_W = 40;
  localparam int SIZE_W = 3;
  localparam int DATA_W = 64;
  localparam int MSHRID_W = 8;
  localparam logic [7:0] BASE = 8'd144;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N_REQ-1:0]        req_valid_i = '0;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*ADDR_W-1:0] req_addr_i = '0;
  logic [N_REQ*SIZE_W-1:0] req_size_i = '0;
  logic                    mem_req_valid_o;
  logic                    mem_req_ready_i = 1'b0;
  logic [ADDR_W-1:0]       mem_req_addr_o;
  logic [SIZE_W-1:0]       mem_req_size_o;
  logic [MSHRID_W-1:0]     mem_req_mshrid_o;
  logic                    mem_resp_valid_i = 1'b0;
  logic [MSHRID_W-1:0]     mem_resp_mshrid_i = '0;
  logic [DATA_W-1:0]       mem_resp_data_i = '0;
  logic [N_REQ-1:0]        resp_valid_o;
  logic [DATA_W-1:0]       resp_data_o;
  logic                    stray_resp_o;

  fifo_ld_req_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_addr_i        (req_addr_i),
    .req_size_i        (req_size_i),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_req_addr_o    (mem_req_addr_o),
    .mem_req_size_o    (mem_req_size_o),
    .mem_req_mshrid_o  (mem_req_mshrid_o),
    .mem_resp_valid_i  (mem_resp_valid_i),
    .mem_resp_mshrid_i (mem_resp_mshrid_i),
    .mem_resp_data_i   (mem_resp_data_i),
    .resp_valid_o      (resp_valid_o),
    .resp_data_o       (resp_data_o),
    .stray_resp_o      (stray_resp_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [SIZE_W-1:0]   size;
    logic [MSHRID_W-1:0] id;
  } slot_t;

  typedef struct {
    logic [3:0] rv;
    logic       mrdy;
    logic       rspv;
    logic [7:0] rid;
    logic [3:0] exp_rdy;
  } vec_t;

  slot_t       sb[$];
  int          cnt_m[N_REQ];
  logic [3:0]  exp_rv = '0;
  logic        exp_stray = 1'b0;
  logic [63:0] exp_data = '0;
  int          n_vec = 0;
  int          n_fail = 0;
  int          step_no = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, step_no, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, compare #1 later, then advance the model.
  task automatic step(input logic [3:0] rv, input logic mrdy, input logic rspv,
                      input logic [7:0] rid, input logic [3:0] exp_rdy);
    logic [ADDR_W-1:0] addr_v[N_REQ];
    logic [SIZE_W-1:0] size_v[N_REQ];
    logic [7:0]        off;
    logic              hit;
    logic [3:0]        acc;
    slot_t             e;
    @(negedge clk);
    step_no++;
    for (int i = 0; i < N_REQ; i++) begin
      addr_v[i] = {8'(8'hA0 + i), 16'h0, 16'(step_no)};
      size_v[i] = 3'(i + step_no);
    end
    req_valid_i       = rv;
    mem_req_ready_i   = mrdy;
    mem_resp_valid_i  = rspv;
    mem_resp_mshrid_i = rid;
    mem_resp_data_i   = {$urandom, $urandom};
    req_addr_i        = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};
    req_size_i        = {size_v[3], size_v[2], size_v[1], size_v[0]};
    #1;
    check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    check("mem_req_valid", 64'(mem_req_valid_o), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("mem_req_addr", 64'(mem_req_addr_o), 64'(sb[0].addr));
      check("mem_req_size", 64'(mem_req_size_o), 64'(sb[0].size));
      check("mem_req_mshrid", 64'(mem_req_mshrid_o), 64'(sb[0].id));
    end
    check("resp_valid", 64'(resp_valid_o), 64'(exp_rv));
    check("stray_resp", 64'(stray_resp_o), 64'(exp_stray));
    if (exp_rv != 0) check("resp_data", resp_data_o, exp_data);

    if (mrdy && sb.size() != 0) void'(sb.pop_front());
    off = rid - BASE;
    hit = rspv && (off < 8'(N_REQ)) && (cnt_m[off[1:0]] > 0);
    acc = rv & exp_rdy;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i]) begin
        e.addr = addr_v[i];
        e.size = size_v[i];
        e.id   = BASE + 8'(i);
        sb.push_back(e);
        cnt_m[i]++;
      end
    end
    exp_rv    = hit ? (4'b0001 << off[1:0]) : 4'b0000;
    exp_stray = rspv && !hit;
    if (hit) begin
      exp_data = mem_resp_data_i;
      cnt_m[off[1:0]]--;
    end
  endtask

  task automatic idle();
    step(4'b0000, 1'b1, 1'b0, 8'd0, 4'b0000);
  endtask

  task automatic resp(input logic [7:0] rid);
    step(4'b0000, 1'b1, 1'b1, rid, 4'b0000);
  endtask

  // Reset with requests pending: no grant while low, reset values after the edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    req_valid_i      = 4'b1111;
    mem_req_ready_i  = 1'b1;
    mem_resp_valid_i = 1'b0;
    #1;
    check("ready_in_reset", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    #1;
    check("ready_in_reset", 64'(req_ready_o), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
    check("rst_mem_req_addr", 64'(mem_req_addr_o), 64'd0);
    check("rst_mem_req_size", 64'(mem_req_size_o), 64'd0);
    check("rst_mem_req_mshrid", 64'(mem_req_mshrid_o), 64'(BASE));
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_resp_data", resp_data_o, 64'd0);
    check("rst_stray", 64'(stray_resp_o), 64'd0);
    rst_n       = 1'b1;
    req_valid_i = '0;
    sb.delete();
    for (int i = 0; i < N_REQ; i++) cnt_m[i] = 0;
    exp_rv    = '0;
    exp_stray = 1'b0;
  endtask

  vec_t tbl[15];

  initial begin
    // Round robin over all four, then route responses and flag strays.
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 8'd0,   4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 1'b0, 8'd0,   4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 1'b0, 8'd0,   4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 8'd0,   4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 8'd0,   4'b0001};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 8'd0,   4'b0000};
    tbl[6]  = '{4'b0000, 1'b1, 1'b1, 8'd144, 4'b0000};
    tbl[7]  = '{4'b0000, 1'b1, 1'b1, 8'd145, 4'b0000};
    tbl[8]  = '{4'b0000, 1'b1, 1'b1, 8'd146, 4'b0000};
    tbl[9]  = '{4'b0000, 1'b1, 1'b1, 8'd147, 4'b0000};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 8'd144, 4'b0000};
    tbl[11] = '{4'b0000, 1'b1, 1'b1, 8'd150, 4'b0000};
    tbl[12] = '{4'b0000, 1'b1, 1'b1, 8'd145, 4'b0000};
    tbl[13] = '{4'b0000, 1'b1, 1'b1, 8'd143, 4'b0000};
    tbl[14] = '{4'b0000, 1'b1, 1'b0, 8'd0,   4'b0000};
    for (int i = 0; i < N_REQ; i++) cnt_m[i] = 0;

    do_reset();
    for (int v = 0; v < 15; v++) begin
      step(tbl[v].rv, tbl[v].mrdy, tbl[v].rspv, tbl[v].rid, tbl[v].exp_rdy);
    end

    // Requester 2 alone hits the cap; one response reopens exactly one grant.
    for (int k = 0; k < 4; k++) step(4'b0100, 1'b1, 1'b0, 8'd0, 4'b0100);
    step(4'b0100, 1'b1, 1'b0, 8'd0,   4'b0000);
    step(4'b0100, 1'b1, 1'b1, 8'd146, 4'b0000);
    step(4'b0100, 1'b1, 1'b0, 8'd0,   4'b0100);
    step(4'b0100, 1'b1, 1'b0, 8'd0,   4'b0000);
    for (int k = 0; k < 4; k++) resp(8'd146);
    idle();

    // Backpressure: slot holds for 5 cycles, then drains and refills together.
    step(4'b1111, 1'b0, 1'b0, 8'd0, 4'b1000);
    for (int k = 0; k < 5; k++) step(4'b1111, 1'b0, 1'b0, 8'd0, 4'b0000);
    step(4'b1111, 1'b1, 1'b0, 8'd0, 4'b0001);
    idle();
    resp(8'd147);
    resp(8'd144);
    idle();

    // Requester 1 at cap: same-cycle response frees it one cycle later; grant skips it.
    for (int k = 0; k < 4; k++) step(4'b0010, 1'b1, 1'b0, 8'd0, 4'b0010);
    step(4'b0010, 1'b1, 1'b0, 8'd0,   4'b0000);
    step(4'b0010, 1'b1, 1'b1, 8'd145, 4'b0000);
    step(4'b0010, 1'b1, 1'b0, 8'd0,   4'b0010);
    step(4'b0001, 1'b1, 1'b0, 8'd0,   4'b0001);
    step(4'b0011, 1'b1, 1'b0, 8'd0,   4'b0001);
    // Accept and matching response for requester 0 in one cycle: net zero.
    step(4'b0001, 1'b1, 1'b1, 8'd144, 4'b0001);
    idle();
    for (int k = 0; k < 4; k++) resp(8'd145);
    resp(8'd144);
    resp(8'd144);
    resp(8'd144);
    idle();

    // Reset while a request is held and cnt[0]=2; late response is then stray.
    step(4'b0001, 1'b1, 1'b0, 8'd0, 4'b0001);
    step(4'b0001, 1'b1, 1'b0, 8'd0, 4'b0001);
    step(4'b0000, 1'b0, 1'b0, 8'd0, 4'b0000);
    do_reset();
    resp(8'd144);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
